// File: rtl/rcc_linepos_pkg.sv
// Shared definitions for the RC-sensor line-position estimator:
// register map, FSM states, channel weights and the divider step.
package rcc_linepos_pkg;

  localparam logic [3:0] REG_POS     = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_FLOOR   = 4'd2;
  localparam logic [3:0] REG_PRESTHR = 4'd3;
  localparam logic [3:0] REG_CONFIG  = 4'd4;

  localparam int unsigned ST_PRESENT    = 0;
  localparam int unsigned ST_OVERRUN    = 1;
  localparam int unsigned ST_INCOMPLETE = 2;
  localparam int unsigned ST_HIT_LSB    = 4;

  localparam int unsigned CFG_ENABLE = 0;
  localparam int unsigned CFG_INVERT = 1;

  localparam int unsigned NUM_W     = 17;
  localparam int unsigned DEN_W     = 10;
  localparam int unsigned DIV_STEPS = 17;

  localparam logic [7:0] W_CH0 = 8'd0;
  localparam logic [7:0] W_CH1 = 8'd85;
  localparam logic [7:0] W_CH2 = 8'd170;
  localparam logic [7:0] W_CH3 = 8'd255;

  localparam logic [7:0] POS_CENTRE    = 8'h80;
  localparam logic [7:0] AUTOSEND_CODE = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    DONE
  } lp_state_e;

  typedef struct packed {
    logic [DEN_W-1:0] rem;
    logic [NUM_W-1:0] quo;
  } div_step_t;

  function automatic logic [7:0] chan_weight(input logic [1:0] ch);
    logic [7:0] w;
    case (ch)
      2'd0:    w = W_CH0;
      2'd1:    w = W_CH1;
      2'd2:    w = W_CH2;
      default: w = W_CH3;
    endcase
    return w;
  endfunction

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic div_step_t div_step(input logic [DEN_W-1:0] rem,
                                         input logic [NUM_W-1:0] quo,
                                         input logic [DEN_W-1:0] dvs);
    div_step_t   r;
    logic [DEN_W:0] sh;
    sh    = {rem, quo[NUM_W-1]};
    r.quo = {quo[NUM_W-2:0], 1'b0};
    if (sh >= {1'b0, dvs}) begin
      sh       = sh - {1'b0, dvs};
      r.quo[0] = 1'b1;
    end
    r.rem = sh[DEN_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rcc_linepos_div.sv
// 17-bit by 10-bit serial restoring divider, one quotient bit per cycle.
// The first bit is resolved in the start cycle; o_done pulses after the 17th.
module rcc_linepos_div
  import rcc_linepos_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_dividend,
  input  logic [DEN_W-1:0] i_divisor,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quotient
);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_dvs;
  logic [NUM_W-1:0] r_quo;
  logic [4:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  div_step_t        w_first;
  div_step_t        w_next;

  always_comb begin
    w_first = div_step('0, i_dividend, i_divisor);
    w_next  = div_step(r_rem, r_quo, r_dvs);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_first.rem;
        r_quo  <= w_first.quo;
        r_dvs  <= i_divisor;
        r_cnt  <= 5'(DIV_STEPS - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_next.rem;
        r_quo <= w_next.quo;
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/rcc_linepos.sv
// Line-position estimator: floor-subtracted weighted centroid of four RC
// sensor channels, with presence/hit flags, exposed on the peripheral bus.
module rcc_linepos
  import rcc_linepos_pkg::*;
#(
  parameter logic [7:0] FLOOR_RST = 8'h10,
  parameter logic [7:0] PRES_RST  = 8'h20
) (
  input  logic       CLK_I,
  input  logic       RSTN_I,
  input  logic       WE_I,
  input  logic       TGA_I,
  input  logic       STB_I,
  input  logic [7:0] ADR_I,
  output logic       STALL_O,
  output logic       ACK_O,
  input  logic [7:0] DAT_I,
  output logic [7:0] DAT_O,
  input  logic       smp_valid,
  input  logic [1:0] smp_chan,
  input  logic [7:0] smp_val,
  input  logic       smp_last
);

  lp_state_e        r_state;
  lp_state_e        w_state_nxt;

  logic [7:0]       r_pos;
  logic             r_present;
  logic             r_overrun;
  logic             r_incomplete;
  logic [3:0]       r_hit;
  logic [7:0]       r_floor;
  logic [7:0]       r_presthr;
  logic             r_enable;
  logic             r_invert;
  logic             r_data_avail;

  logic [NUM_W-1:0] r_num;
  logic [DEN_W-1:0] r_den;
  logic [3:0]       r_seen;
  logic [3:0]       r_hit_acc;

  logic             w_myaddr;
  logic             w_rd;
  logic             w_wr;
  logic [7:0]       w_c;
  logic [7:0]       w_v;
  logic [15:0]      w_prod;
  logic             w_fresh;
  logic             w_accept;
  logic             w_drop;
  logic             w_finish;
  logic             w_complete;
  logic             w_div_start;
  logic             w_div_done;
  logic [NUM_W-1:0] w_quo;
  logic [NUM_W-1:0] w_num_nxt;
  logic [DEN_W-1:0] w_den_nxt;
  logic [3:0]       w_seen_nxt;
  logic [3:0]       w_hit_nxt;
  logic [7:0]       w_pos_res;
  logic [7:0]       w_status;
  logic [7:0]       w_reg_rd;

  assign w_myaddr = STB_I & (ADR_I[7:4] == 4'h0);
  assign w_rd     = TGA_I & w_myaddr & ~WE_I;
  assign w_wr     = TGA_I & w_myaddr & WE_I;
  assign STALL_O  = 1'b0;
  assign ACK_O    = w_myaddr;

  // Sample transform and running accumulation; a frame restarts from zero in IDLE.
  always_comb begin
    w_c    = r_invert ? ~smp_val : smp_val;
    w_v    = (w_c > r_floor) ? (w_c - r_floor) : '0;
    w_prod = 16'(w_v) * 16'(chan_weight(smp_chan));

    w_fresh    = (r_state == IDLE);
    w_num_nxt  = (w_fresh ? '0 : r_num) + NUM_W'(w_prod);
    w_den_nxt  = (w_fresh ? '0 : r_den) + DEN_W'(w_v);
    w_seen_nxt = w_fresh ? '0 : r_seen;
    w_hit_nxt  = w_fresh ? '0 : r_hit_acc;
    w_seen_nxt[smp_chan] = 1'b1;
    w_hit_nxt[smp_chan]  = (w_v != '0);
    w_complete = (w_seen_nxt == 4'hF);

    w_accept    = smp_valid & r_enable & ((r_state == IDLE) | (r_state == ACCUM));
    w_drop      = smp_valid & r_enable & ((r_state == DIVIDE) | (r_state == DONE));
    w_finish    = r_enable & (r_state == DONE);
    w_div_start = w_accept & smp_last & w_complete;
  end

  rcc_linepos_div u_div (
    .i_clk      (CLK_I),
    .i_rst_n    (RSTN_I),
    .i_start    (w_div_start),
    .i_dividend (w_num_nxt),
    .i_divisor  (w_den_nxt),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (!r_enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (smp_valid && !smp_last) w_state_nxt = ACCUM;
        ACCUM:   if (smp_valid && smp_last)  w_state_nxt = w_complete ? DIVIDE : IDLE;
        DIVIDE:  if (w_div_done)             w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    if (r_den == '0)          w_pos_res = POS_CENTRE;
    else if (|w_quo[16:8])    w_pos_res = 8'hFF;
    else                      w_pos_res = w_quo[7:0];
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_pos        <= POS_CENTRE;
      r_present    <= 1'b0;
      r_overrun    <= 1'b0;
      r_incomplete <= 1'b0;
      r_hit        <= '0;
      r_floor      <= FLOOR_RST;
      r_presthr    <= PRES_RST;
      r_enable     <= 1'b0;
      r_invert     <= 1'b0;
      r_data_avail <= 1'b0;
      r_num        <= '0;
      r_den        <= '0;
      r_seen       <= '0;
      r_hit_acc    <= '0;
    end else begin
      if (w_wr) begin
        case (ADR_I[3:0])
          REG_FLOOR:   r_floor   <= DAT_I;
          REG_PRESTHR: r_presthr <= DAT_I;
          REG_CONFIG: begin
            r_enable <= DAT_I[CFG_ENABLE];
            r_invert <= DAT_I[CFG_INVERT];
          end
          default: ;
        endcase
      end

      if (w_accept) begin
        r_num     <= w_num_nxt;
        r_den     <= w_den_nxt;
        r_seen    <= w_seen_nxt;
        r_hit_acc <= w_hit_nxt;
        if (smp_last && !w_complete) r_incomplete <= 1'b1;
      end

      // Set after clear so a dropped sample wins over a coincident status read.
      if (w_rd && (ADR_I[3:0] == REG_STATUS)) r_overrun <= 1'b0;
      if (w_drop)                             r_overrun <= 1'b1;

      if (w_rd) r_data_avail <= 1'b0;
      if (w_finish) begin
        r_pos        <= w_pos_res;
        r_present    <= (r_den[DEN_W-1:2] >= r_presthr);
        r_hit        <= r_hit_acc;
        r_incomplete <= 1'b0;
        r_data_avail <= 1'b1;
      end
    end
  end

  always_comb begin
    w_status                 = '0;
    w_status[ST_PRESENT]     = r_present;
    w_status[ST_OVERRUN]     = r_overrun;
    w_status[ST_INCOMPLETE]  = r_incomplete;
    w_status[ST_HIT_LSB +: 4] = r_hit;

    w_reg_rd = '0;
    case (ADR_I[3:0])
      REG_POS:     w_reg_rd = r_pos;
      REG_STATUS:  w_reg_rd = w_status;
      REG_FLOOR:   w_reg_rd = r_floor;
      REG_PRESTHR: w_reg_rd = r_presthr;
      REG_CONFIG: begin
        w_reg_rd[CFG_ENABLE] = r_enable;
        w_reg_rd[CFG_INVERT] = r_invert;
      end
      default: ;
    endcase

    DAT_O = DAT_I;
    if (w_myaddr) begin
      if (TGA_I)             DAT_O = w_reg_rd;
      else if (r_data_avail) DAT_O = AUTOSEND_CODE;
      else                   DAT_O = '0;
    end
  end

endmodule
